// File: rtl/lda_pkg.sv
// Shared types and helpers for the streaming Bresenham line engine.
// Step direction is held as a single sign bit rather than a signed +1/-1 value.
package lda_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PLOT,
        DONE,
        WAIT
    } state_t;

    typedef logic dir_t;
    localparam dir_t DIR_POS = 1'b0;
    localparam dir_t DIR_NEG = 1'b1;

    // Signed error width: the wider coordinate plus sign and headroom for err+dx.
    function automatic int calc_ew(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 2;
    endfunction

endpackage

// File: rtl/lda_step.sv
// Combinational single Bresenham step: advances (x,y) and the error term.
// Both axis decisions use the incoming err, so a diagonal move happens in one step.
module lda_step
    import lda_pkg::*;
#(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int EW = calc_ew(XW, YW)
) (
    input  logic signed [EW-1:0] err,
    input  logic signed [EW-1:0] dx,
    input  logic signed [EW-1:0] dy,
    input  dir_t                 sx,
    input  dir_t                 sy,
    input  logic [XW-1:0]        x,
    input  logic [YW-1:0]        y,
    output logic signed [EW-1:0] err_next,
    output logic [XW-1:0]        x_next,
    output logic [YW-1:0]        y_next
);

    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);

    logic signed [EW:0]   e2;
    logic signed [EW:0]   dx_w;
    logic signed [EW:0]   dy_w;
    logic                 step_x;
    logic                 step_y;
    logic signed [EW-1:0] add_x;
    logic signed [EW-1:0] add_y;

    assign e2     = {err, 1'b0};
    assign dx_w   = {dx[EW-1], dx};
    assign dy_w   = {dy[EW-1], dy};
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);
    assign add_x  = step_x ? dy : {EW{1'b0}};
    assign add_y  = step_y ? dx : {EW{1'b0}};

    always_comb begin
        err_next = err + add_x + add_y;
        x_next   = x;
        y_next   = y;
        if (step_x) begin
            x_next = (sx == DIR_NEG) ? (x - X_ONE) : (x + X_ONE);
        end
        if (step_y) begin
            y_next = (sy == DIR_NEG) ? (y - Y_ONE) : (y + Y_ONE);
        end
    end

endmodule

// File: rtl/lda_stream.sv
// Streaming Bresenham line drawer: latches a line on go and emits its pixels
// in order over a valid/ready handshake, then pulses done.
module lda_stream
    import lda_pkg::*;
#(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          go,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          pix_valid,
    input  logic          pix_ready
);

    localparam int EW = calc_ew(XW, YW);

    state_t               state_reg;
    state_t               state_next;
    logic [XW-1:0]        x0_reg;
    logic [XW-1:0]        x1_reg;
    logic [YW-1:0]        y0_reg;
    logic [YW-1:0]        y1_reg;
    logic signed [EW-1:0] dx_reg;
    logic signed [EW-1:0] dy_reg;
    logic signed [EW-1:0] err_reg;
    dir_t                 sx_reg;
    dir_t                 sy_reg;

    logic [XW-1:0]        adx;
    logic [YW-1:0]        ady;
    logic signed [EW-1:0] err_step;
    logic [XW-1:0]        x_step;
    logic [YW-1:0]        y_step;
    logic                 hs;
    logic                 at_end;

    assign adx    = (x1_reg >= x0_reg) ? (x1_reg - x0_reg) : (x0_reg - x1_reg);
    assign ady    = (y1_reg >= y0_reg) ? (y1_reg - y0_reg) : (y0_reg - y1_reg);
    // Decoded from the state register so the handshake has no path through the FSM outputs.
    assign hs     = (state_reg == PLOT) && pix_ready;
    assign at_end = (pix_x == x1_reg) && (pix_y == y1_reg);

    lda_step #(
        .XW(XW),
        .YW(YW),
        .EW(EW)
    ) u_step (
        .err      (err_reg),
        .dx       (dx_reg),
        .dy       (dy_reg),
        .sx       (sx_reg),
        .sy       (sy_reg),
        .x        (pix_x),
        .y        (pix_y),
        .err_next (err_step),
        .x_next   (x_step),
        .y_next   (y_step)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        pix_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                busy       = 1'b1;
                state_next = PLOT;
            end
            PLOT: begin
                busy      = 1'b1;
                pix_valid = 1'b1;
                if (hs && at_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A held go must be released before another line can start.
                if (!go) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x0_reg     <= '0;
            x1_reg     <= '0;
            y0_reg     <= '0;
            y1_reg     <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            err_reg    <= '0;
            sx_reg     <= DIR_POS;
            sy_reg     <= DIR_POS;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        x0_reg     <= x0;
                        y0_reg     <= y0;
                        x1_reg     <= x1;
                        y1_reg     <= y1;
                        pix_colour <= colour;
                    end
                end
                SETUP: begin
                    dx_reg  <= $signed(EW'(adx));
                    dy_reg  <= -$signed(EW'(ady));
                    err_reg <= $signed(EW'(adx)) - $signed(EW'(ady));
                    sx_reg  <= (x0_reg < x1_reg) ? DIR_POS : DIR_NEG;
                    sy_reg  <= (y0_reg < y1_reg) ? DIR_POS : DIR_NEG;
                    pix_x   <= x0_reg;
                    pix_y   <= y0_reg;
                end
                PLOT: begin
                    if (hs && !at_end) begin
                        err_reg <= err_step;
                        pix_x   <= x_step;
                        pix_y   <= y_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lda_stream.sv
// Directed bench for lda_stream: table of short lines with hand-computed pixels,
// plus full-range, reset-abort and held-go sequences.
module tb_lda_stream;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          go = 1'b0;
    logic [XW-1:0] x0 = '0;
    logic [YW-1:0] y0 = '0;
    logic [XW-1:0] x1 = '0;
    logic [YW-1:0] y1 = '0;
    logic [CW-1:0] colour = '0;
    logic          busy;
    logic          done;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [CW-1:0] pix_colour;
    logic          pix_valid;
    logic          pix_ready = 1'b0;

    lda_stream #(.XW(XW), .YW(YW), .CW(CW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .go         (go),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .colour     (colour),
        .busy       (busy),
        .done       (done),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    int qx[$];
    int qy[$];
    int qc[$];
    int first_c;
    int last_hs_c;
    int done_c;

    typedef struct {
        int              x0, y0, x1, y1, col;
        bit              stall;
        bit              hold;
        int              n;
        logic [7:0][15:0] px;
        logic [7:0][15:0] py;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0][15:0] mk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [7:0][15:0] r;
        r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
        r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
        return r;
    endfunction

    // Starts one line and collects every accepted pixel into qx/qy/qc.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int acol, input bit stall, input bit hold_go,
                            input string tag);
        int c;
        int rc;
        int snap;
        int cnt;
        bit prev_stall;
        qx.delete();
        qy.delete();
        qc.delete();
        first_c = -1;
        last_hs_c = -1;
        done_c = -1;
        rc = 0;
        snap = 0;
        prev_stall = 1'b0;
        @(negedge clock);
        x0 = XW'(ax0);
        y0 = YW'(ay0);
        x1 = XW'(ax1);
        y1 = YW'(ay1);
        colour = CW'(acol);
        go = 1'b1;
        pix_ready = 1'b0;
        @(negedge clock);
        chk({tag, " busy_after_go"}, int'(busy), 1);
        if (!hold_go) go = 1'b0;
        c = 1;
        while (c < 2000) begin
            if (done === 1'b1) begin
                done_c = c;
                chk({tag, " busy_at_done"}, int'(busy), 0);
                break;
            end
            if (prev_stall) chk({tag, " valid_during_stall"}, int'(pix_valid), 1);
            if (pix_valid === 1'b1) begin
                if (prev_stall) chk({tag, " stall_hold"}, int'({pix_x, pix_y, pix_colour}), snap);
                if (first_c < 0) first_c = c;
                pix_ready = stall ? (rc % 3 == 0) : 1'b1;
                rc++;
                if (pix_ready) begin
                    qx.push_back(int'(pix_x));
                    qy.push_back(int'(pix_y));
                    qc.push_back(int'(pix_colour));
                    last_hs_c = c;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    snap = int'({pix_x, pix_y, pix_colour});
                end
            end else begin
                pix_ready = 1'b0;
                prev_stall = 1'b0;
            end
            @(negedge clock);
            c++;
        end
        if (done_c < 0) chk({tag, " timeout_waiting_done"}, 0, 1);
        pix_ready = 1'b0;
        @(negedge clock);
        chk({tag, " done_one_cycle"}, int'(done), 0);
        if (hold_go) begin
            cnt = 0;
            repeat (10) begin
                @(negedge clock);
                cnt += int'(pix_valid | busy);
            end
            chk({tag, " held_go_redraw"}, cnt, 0);
            go = 1'b0;
            @(negedge clock);
        end
        @(negedge clock);
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        chk({tag, " count"}, qx.size(), v.n);
        for (int i = 0; i < v.n && i < qx.size(); i++) begin
            chk($sformatf("%s px[%0d]", tag, i), qx[i], int'(v.px[i]));
            chk($sformatf("%s py[%0d]", tag, i), qy[i], int'(v.py[i]));
            chk($sformatf("%s colour[%0d]", tag, i), qc[i], v.col);
        end
        chk({tag, " first_valid_latency"}, first_c, 2);
        chk({tag, " done_after_last"}, done_c, last_hs_c + 1);
        if (!v.stall) chk({tag, " back_to_back"}, last_hs_c - first_c + 1, v.n);
    endtask

    initial begin
        int mx[$];
        int my[$];
        int k;

        vecs[0] = '{x0: 0, y0: 0, x1: 3, y1: 0, col: 2, stall: 0, hold: 0, n: 4,
                    px: mk8(0, 1, 2, 3, 0, 0, 0, 0), py: mk8(0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1] = '{x0: 2, y0: 4, x1: 0, y1: 0, col: 6, stall: 0, hold: 0, n: 5,
                    px: mk8(2, 1, 1, 0, 0, 0, 0, 0), py: mk8(4, 3, 2, 1, 0, 0, 0, 0)};
        vecs[2] = '{x0: 7, y0: 5, x1: 7, y1: 5, col: 5, stall: 0, hold: 1, n: 1,
                    px: mk8(7, 0, 0, 0, 0, 0, 0, 0), py: mk8(5, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3] = '{x0: 0, y0: 0, x1: 3, y1: 3, col: 1, stall: 1, hold: 0, n: 4,
                    px: mk8(0, 1, 2, 3, 0, 0, 0, 0), py: mk8(0, 1, 2, 3, 0, 0, 0, 0)};
        vecs[4] = '{x0: 0, y0: 0, x1: 5, y1: 2, col: 3, stall: 0, hold: 0, n: 6,
                    px: mk8(0, 1, 2, 3, 4, 5, 0, 0), py: mk8(0, 0, 1, 1, 2, 2, 0, 0)};

        // Reset state
        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset pix_valid", int'(pix_valid), 0);
        chk("reset pix_x", int'(pix_x), 0);
        chk("reset pix_y", int'(pix_y), 0);
        chk("reset pix_colour", int'(pix_colour), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int v = 0; v < 5; v++) begin
            run_line(vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].col,
                     vecs[v].stall, vecs[v].hold, $sformatf("vec%0d", v));
            check_vec(vecs[v], $sformatf("vec%0d", v));
            $display("vec%0d (%0d,%0d)->(%0d,%0d): %0d pixels", v, vecs[v].x0, vecs[v].y0,
                     vecs[v].x1, vecs[v].y1, qx.size());
        end

        // Full-range line against a Bresenham reference
        begin
            int x, y, dx, dy, err, e2, sx, sy;
            x = 511; y = 0; dx = 511; dy = -255; err = dx + dy; sx = -1; sy = 1;
            forever begin
                mx.push_back(x);
                my.push_back(y);
                if (x == 0 && y == 255) break;
                e2 = 2 * err;
                if (e2 >= dy) begin err += dy; x += sx; end
                if (e2 <= dx) begin err += dx; y += sy; end
            end
        end
        run_line(511, 0, 0, 255, 7, 1'b0, 1'b0, "extreme");
        chk("extreme count", qx.size(), 512);
        chk("extreme model count", mx.size(), 512);
        if (qx.size() > 0) begin
            chk("extreme first x", qx[0], 511);
            chk("extreme first y", qy[0], 0);
            chk("extreme last x", qx[qx.size()-1], 0);
            chk("extreme last y", qy[qy.size()-1], 255);
        end
        for (int i = 0; i < mx.size() && i < qx.size(); i++) begin
            if (qx[i] != mx[i] || qy[i] != my[i]) begin
                chk($sformatf("extreme pixel %0d xy", i), qx[i] * 1000 + qy[i], mx[i] * 1000 + my[i]);
            end
        end
        chk("extreme done_after_last", done_c, last_hs_c + 1);
        $display("extreme (511,0)->(0,255): %0d pixels", qx.size());

        // Reset asserted mid-line after the third pixel is accepted
        @(negedge clock);
        x0 = 9'd0; y0 = 8'd0; x1 = 9'd9; y1 = 8'd0; colour = 3'd6;
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            pix_ready = pix_valid;
            if (pix_valid === 1'b1) k++;
            if (k < 3) @(negedge clock);
        end
        chk("abort handshakes before reset", k, 3);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort pix_valid", int'(pix_valid), 0);
        chk("abort pix_x", int'(pix_x), 0);
        chk("abort pix_y", int'(pix_y), 0);
        chk("abort pix_colour", int'(pix_colour), 0);
        @(negedge clock);
        reset_n = 1'b1;
        pix_ready = 1'b1;
        k = 0;
        repeat (6) begin
            @(negedge clock);
            k += int'(done | pix_valid | busy);
        end
        chk("abort no activity after reset", k, 0);
        pix_ready = 1'b0;
        $display("abort: reset mid-line, outputs cleared");

        run_line(1, 1, 3, 2, 4, 1'b0, 1'b0, "post_reset");
        chk("post_reset count", qx.size(), 3);
        if (qx.size() == 3) begin
            chk("post_reset p0", qx[0] * 1000 + qy[0], 1001);
            chk("post_reset p1", qx[1] * 1000 + qy[1], 2002);
            chk("post_reset p2", qx[2] * 1000 + qy[2], 3002);
            chk("post_reset colour", qc[0], 4);
        end
        chk("post_reset first_valid_latency", first_c, 2);
        $display("post_reset (1,1)->(3,2): %0d pixels", qx.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
